// File: rtl/axi_sram_ctrl_if.sv
// AXI4 bus bundle between an interconnect slave port and axi_sram_ctrl.
// Carries the five AXI channels (AW, W, B, AR, R); SRAM pins are not part of it.
//   master : interconnect side (drives AW/W/AR payload+valid, B/R ready)
//   slave  : controller side (drives AW/W/AR ready, B/R payload+valid)
interface axi_sram_ctrl_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_sram_ctrl.sv
// AXI4 slave that sequences one single-port SRAM wrapper (one-cycle read latency).
// One transaction in flight; AW/AR arbitrated round-robin; every burst treated as
// INCR word-sized; each beat becomes exactly one SRAM access.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   s          : AXI4 slave modport (AW, W, B, AR, R channels)
//   ceb, web   : SRAM chip enable / write enable, both active-low
//   bweb       : SRAM per-bit write mask, active-low
//   a, di      : SRAM word address / write data (hold last value when idle)
//   dout       : SRAM read data, valid the cycle after a read access
module axi_sram_ctrl #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_sram_ctrl_if.slave     s,
    output logic               ceb,
    output logic               web,
    output logic [DATA_W-1:0]  bweb,
    output logic [SRAM_AW-1:0] a,
    output logic [DATA_W-1:0]  di,
    input  logic [DATA_W-1:0]  dout
);
    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA
    } state_t;

    state_t             state;
    logic [SRAM_AW-1:0] addr_q;     // address of the next beat
    logic [SRAM_AW-1:0] a_q;        // address of the last SRAM access
    logic [DATA_W-1:0]  di_q;       // data of the last SRAM write
    logic [DATA_W-1:0]  rdata_q;
    logic [ID_W-1:0]    id_q;
    logic [3:0]         cnt_q;      // beats remaining after the current one
    logic               last_wr_q;  // last grant went to the write channel

    logic grant_wr, grant_rd, wr_beat, rd_acc, access;

    // Tie goes to whichever class was not granted last; gated by rst_n so the
    // ready lines stay low while reset is asserted.
    assign grant_wr = rst_n && state == IDLE && s.awvalid && (!s.arvalid || !last_wr_q);
    assign grant_rd = rst_n && state == IDLE && s.arvalid && (!s.awvalid ||  last_wr_q);
    assign wr_beat  = state == WR_DATA && s.wvalid;
    assign rd_acc   = state == RD_ISSUE;
    assign access   = wr_beat || rd_acc;

    assign s.awready = grant_wr;
    assign s.arready = grant_rd;
    assign s.wready  = state == WR_DATA;
    assign s.bvalid  = state == WR_RESP;
    assign s.bid     = id_q;
    assign s.bresp   = 2'b00;
    assign s.rvalid  = state == RD_DATA;
    assign s.rdata   = rdata_q;
    assign s.rid     = id_q;
    assign s.rresp   = 2'b00;
    assign s.rlast   = state == RD_DATA && cnt_q == 4'd0;

    // SRAM strobes are decoded from state so reset forces ceb high immediately.
    assign ceb = !access;
    assign web = !wr_beat;
    assign a   = access  ? addr_q  : a_q;
    assign di  = wr_beat ? s.wdata : di_q;

    always_comb begin
        bweb = '1;
        if (wr_beat)
            for (int i = 0; i < DATA_W/8; i++)
                bweb[8*i +: 8] = {8{~s.wstrb[i]}};
    end

    // Burst type, size, WLAST and the byte/upper address bits play no part.
    logic unused_ok;
    assign unused_ok = ^{s.awaddr[ADDR_W-1:SRAM_AW+2], s.awaddr[1:0], s.awsize, s.awburst,
                         s.araddr[ADDR_W-1:SRAM_AW+2], s.araddr[1:0], s.arsize, s.arburst,
                         s.wlast};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            a_q       <= '0;
            di_q      <= '0;
            rdata_q   <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
        end else begin
            if (access)  a_q  <= addr_q;
            if (wr_beat) di_q <= s.wdata;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        id_q      <= s.awid;
                        addr_q    <= s.awaddr[SRAM_AW+1:2];
                        cnt_q     <= s.awlen;
                        last_wr_q <= 1'b1;
                        state     <= WR_DATA;
                    end else if (grant_rd) begin
                        id_q      <= s.arid;
                        addr_q    <= s.araddr[SRAM_AW+1:2];
                        cnt_q     <= s.arlen;
                        last_wr_q <= 1'b0;
                        state     <= RD_ISSUE;
                    end
                end
                WR_DATA: begin
                    if (s.wvalid) begin
                        // Beat count, not WLAST, ends the burst; address wraps.
                        addr_q <= addr_q + SRAM_AW'(1);
                        cnt_q  <= cnt_q - 4'd1;
                        if (cnt_q == 4'd0) state <= WR_RESP;
                    end
                end
                WR_RESP: if (s.bready) state <= IDLE;
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    rdata_q <= dout;
                    state   <= RD_DATA;
                end
                RD_DATA: begin
                    if (s.rready) begin
                        if (cnt_q == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= addr_q + SRAM_AW'(1);
                            cnt_q  <= cnt_q - 4'd1;
                            state  <= RD_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Directed bench for axi_sram_ctrl with a behavioural single-port SRAM.
module tb_axi_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ceb, web;
    logic [31:0] bweb, di, dout;
    logic [13:0] a;

    axi_sram_ctrl_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_sram_ctrl #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .SRAM_AW(14)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus),
        .ceb(ceb), .web(web), .bweb(bweb), .a(a), .di(di), .dout(dout)
    );

    always #5 clk = ~clk;

    // SRAM: masked write, one-cycle registered read
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (!ceb) begin
            if (!web) mem[a] <= (mem[a] & bweb) | (di & ~bweb);
            else      dout   <= mem[a];
        end
    end

    // 1 = write grant, 0 = read grant, in handshake order
    logic grant_log [$];
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.awvalid && bus.awready) grant_log.push_back(1'b1);
            if (bus.arvalid && bus.arready) grant_log.push_back(1'b0);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] eb [16];
    logic [31:0] re [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the B handshake edge.
    // rst_at >= 0 asserts reset in the middle of that beat and abandons the burst.
    task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input int nb,
                          input bit gap, input logic [13:0] a0, input int rst_at);
        int k;
        logic [13:0] ea;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(nb - 1);
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.awready && k < 40) begin @(negedge clk); k++; end
        chk("aw_grant", {31'd0, bus.awready}, 32'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gap && i > 0) begin
                bus.wvalid = 1'b0;
                @(negedge clk);
                chk("wr_gap_ceb", {31'd0, ceb}, 32'd1);
                chk("wr_gap_bweb", bweb, 32'hFFFF_FFFF);
                @(posedge clk); #1;
            end
            ea = a0 + 14'(i);
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == nb - 1); bus.wvalid = 1'b1;
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_ceb", {31'd0, ceb}, 32'd1);
                chk("rst_web", {31'd0, web}, 32'd1);
                chk("rst_rdy", {28'd0, bus.wready, bus.awready, bus.arready, bus.bvalid}, 32'd0);
                chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
                bus.wvalid = 1'b0;
                return;
            end
            @(negedge clk);
            if (i == 0) chk("wready_t1", {31'd0, bus.wready}, 32'd1);
            if (i == 0) chk("awready_drop", {31'd0, bus.awready}, 32'd0);
            chk("wr_cebweb", {30'd0, ceb, web}, 32'd0);
            chk("wr_a", {18'd0, a}, {18'd0, ea});
            chk("wr_di", di, wd[i]);
            chk("wr_bweb", bweb, eb[i]);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid", {31'd0, bus.bvalid}, 32'd1);
        chk("bid", {28'd0, bus.bid}, {28'd0, id});
        chk("bresp", {30'd0, bus.bresp}, 32'd0);
        chk("wr_done_ceb", {31'd0, ceb}, 32'd1);
        bus.bready = 1'b1;
        @(posedge clk); #1 bus.bready = 1'b0;
    endtask

    // Called #1 after a posedge; returns #1 after the final R handshake edge.
    task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input int nb,
                          input int stall, input logic [13:0] a0);
        int k;
        logic [13:0] ea;
        bus.arid = id; bus.araddr = addr; bus.arlen = 4'(nb - 1);
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.arready && k < 40) begin @(negedge clk); k++; end
        chk("ar_grant", {31'd0, bus.arready}, 32'd1);
        @(posedge clk); #1 bus.arvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            ea = a0 + 14'(i);
            @(negedge clk);
            chk("rd_cebweb", {30'd0, ceb, web}, 32'd1);
            chk("rd_a", {18'd0, a}, {18'd0, ea});
            @(posedge clk); #1;
            @(negedge clk);
            chk("rd_wait_rvalid", {31'd0, bus.rvalid}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rvalid_t3", {31'd0, bus.rvalid}, 32'd1);
            if (i == 0) begin
                repeat (stall) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("stall_rvalid", {31'd0, bus.rvalid}, 32'd1);
                    chk("stall_rdata", bus.rdata, re[i]);
                end
            end
            chk("rdata", bus.rdata, re[i]);
            chk("rlast", {31'd0, bus.rlast}, {31'd0, i == nb - 1});
            chk("rid", {28'd0, bus.rid}, {28'd0, id});
            chk("rresp", {30'd0, bus.rresp}, 32'd0);
            bus.rready = 1'b1;
            @(posedge clk); #1 bus.rready = 1'b0;
        end
    endtask

    initial begin
        logic gexp [7];
        gexp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // reset state
        #12;
        chk("reset_rdy", {29'd0, bus.awready, bus.arready, bus.wready}, 32'd0);
        chk("reset_vld", {29'd0, bus.bvalid, bus.rvalid, bus.rlast}, 32'd0);
        chk("reset_ids", {24'd0, bus.bid, bus.rid}, 32'd0);
        chk("reset_resp", {28'd0, bus.bresp, bus.rresp}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_cebweb", {30'd0, ceb, web}, 32'd3);
        chk("reset_bweb", bweb, 32'hFFFF_FFFF);
        chk("reset_a", {18'd0, a}, 32'd0);
        chk("reset_di", di, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single write, readback
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; eb[0] = 32'h0;
        axi_wr(4'h1, 32'h0000_0010, 1, 1'b0, 14'h004, -1);
        re[0] = 32'hDEAD_BEEF;
        axi_rd(4'h2, 32'h0000_0010, 1, 0, 14'h004);
        chk("idle_a_holds", {18'd0, a}, 32'h004);

        // byte strobes
        wd[0] = 32'h1122_3344; ws[0] = 4'hF; eb[0] = 32'h0;
        axi_wr(4'h1, 32'h0000_0020, 1, 1'b0, 14'h008, -1);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5; eb[0] = 32'hFF00_FF00;
        axi_wr(4'h1, 32'h0000_0020, 1, 1'b0, 14'h008, -1);
        re[0] = 32'h11BB_33DD;
        axi_rd(4'h3, 32'h0000_0020, 1, 0, 14'h008);

        // fresh reset so the last-grant flag is back at "write"
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        grant_log.delete();

        // tie 1: read first, then write
        bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0200; bus.awlen = 4'd0;
        re[0] = 32'hDEAD_BEEF;
        axi_rd(4'h4, 32'h0000_0010, 1, 0, 14'h004);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF; eb[0] = 32'h0;
        axi_wr(4'h4, 32'h0000_0200, 1, 1'b0, 14'h080, -1);
        // tie 2: last grant was write, so read again first
        bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0204; bus.awlen = 4'd0;
        re[0] = 32'h1234_5678;
        axi_rd(4'h4, 32'h0000_0200, 1, 0, 14'h080);
        wd[0] = 32'h9ABC_DEF0;
        axi_wr(4'h4, 32'h0000_0204, 1, 1'b0, 14'h081, -1);
        // lone read, then tie 3 must go to the write
        re[0] = 32'h9ABC_DEF0;
        axi_rd(4'h4, 32'h0000_0204, 1, 0, 14'h081);
        bus.arvalid = 1'b1; bus.araddr = 32'h0000_0200; bus.arlen = 4'd0;
        wd[0] = 32'h0F0F_0F0F;
        axi_wr(4'h4, 32'h0000_0208, 1, 1'b0, 14'h082, -1);
        re[0] = 32'h1234_5678;
        axi_rd(4'h4, 32'h0000_0200, 1, 0, 14'h080);
        chk("grant_count", grant_log.size(), 32'd7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++)
            chk("grant_order", {31'd0, grant_log[i]}, {31'd0, gexp[i]});

        // 4-beat INCR write with WVALID gaps, 4-beat readback with ID 5
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; eb[i] = 32'h0; re[i] = wd[i];
        end
        axi_wr(4'h6, 32'h0000_0100, 4, 1'b1, 14'h040, -1);
        axi_rd(4'h5, 32'h0000_0100, 4, 0, 14'h040);

        // wrap at the top of the SRAM, read stalled 5 cycles
        wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002;
        ws[0] = 4'hF; ws[1] = 4'hF; eb[0] = 32'h0; eb[1] = 32'h0;
        axi_wr(4'h2, 32'h0000_FFFC, 2, 1'b0, 14'h3FFF, -1);
        re[0] = 32'hCAFE_0001; re[1] = 32'hCAFE_0002;
        axi_rd(4'h2, 32'h0000_FFFC, 2, 5, 14'h3FFF);

        // reset during beat 2 of 4, then a normal write/read
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hB000_0000 + 32'(i); ws[i] = 4'hF; eb[i] = 32'h0;
        end
        axi_wr(4'h7, 32'h0000_0300, 4, 1'b0, 14'h0C0, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, bus.bvalid, bus.wready}, 32'd0);
        @(posedge clk); #1;
        wd[0] = 32'h55AA_55AA; ws[0] = 4'hF; eb[0] = 32'h0;
        axi_wr(4'h8, 32'h0000_0300, 1, 1'b0, 14'h0C0, -1);
        re[0] = 32'h55AA_55AA;
        axi_rd(4'h9, 32'h0000_0300, 1, 0, 14'h0C0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
